// File: rtl/wb_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN0    = 2'd1,
    ST_OWN1    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone bus bundle. The "master" side drives the request, the "slave"
// side answers it. The slave of this arbiter never raises err, so the
// master modport leaves err out.
interface wb_arbiter2_if;
  logic        cyc;
  logic [3:0]  stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, addr, wdat, input rdat, ack);
  modport slave  (input cyc, stb, we, addr, wdat, output rdat, ack, err);
endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Saturating bus watchdog. tc is raised combinationally on the cycle the
// count of enabled cycles reaches TIMEOUT (count == TIMEOUT-1 plus this one).
module wb_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  if ((TIMEOUT < 2) || (TIMEOUT >= (1 << TO_W))) begin : g_bad_timeout
    $error("wb_watchdog: TIMEOUT out of range for TO_W");
  end

  localparam logic [TO_W-1:0] TC_VAL  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  logic [TO_W-1:0] count;

  // Count enabled cycles; clear wins, saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + TO_W'(1);
    end
  end

  assign tc = en && (count >= TC_VAL);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter, round-robin on ties, grant held for a whole
// CYC, with a watchdog that terminates a hung slave with a poison ack.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner; arbitrate, registered grant next cycle
// ST_OWN0    | master 0 owns the slave bus, combinational mux
// ST_OWN1    | master 1 owns the slave bus, combinational mux
// ST_RELEASE | owner got a timeout error; bus parked until it drops cyc
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int          TIMEOUT      = 255,
  parameter int          TO_W         = 8,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst_n,
  wb_arbiter2_if.slave        m0,
  wb_arbiter2_if.slave        m1,
  wb_arbiter2_if.master       s,
  output logic [1:0]          o_grant,
  output logic                o_timeout
);

  state_t      state, state_nx;
  logic        last_owner, last_nx;
  logic [1:0]  grant, grant_nx;

  logic        sel;
  logic        own;
  logic        sel_cyc;
  logic [3:0]  sel_stb;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdat;

  logic        s_cyc_c;
  logic [3:0]  s_stb_c;
  logic        rsp_ack;
  logic        rsp_err;
  logic [31:0] rsp_dat;
  logic        timeout_c;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_tc;

  // Owner index comes from the registered grant (01 / 10 while owned).
  assign sel      = grant[1];
  assign own      = (state == ST_OWN0) || (state == ST_OWN1);
  assign sel_cyc  = sel ? m1.cyc  : m0.cyc;
  assign sel_stb  = sel ? m1.stb  : m0.stb;
  assign sel_we   = sel ? m1.we   : m0.we;
  assign sel_addr = sel ? m1.addr : m0.addr;
  assign sel_wdat = sel ? m1.wdat : m0.wdat;

  wb_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (i_wb_clk),
    .rst_n (i_wb_rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  // State, round-robin history and registered grant.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      grant      <= GRANT_NONE;
    end else begin
      state      <= state_nx;
      last_owner <= last_nx;
      grant      <= grant_nx;
    end
  end

  // Arbitration, slave-side mux gating, response steering and watchdog control.
  always_comb begin
    state_nx  = state;
    last_nx   = last_owner;
    grant_nx  = grant;
    s_cyc_c   = 1'b0;
    s_stb_c   = 4'h0;
    rsp_ack   = 1'b0;
    rsp_err   = 1'b0;
    rsp_dat   = 32'h0;
    timeout_c = 1'b0;
    wd_clr    = 1'b1;
    wd_en     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (m0.cyc && (!m1.cyc || last_owner)) begin
          state_nx = ST_OWN0;
          grant_nx = GRANT_M0;
        end else if (m1.cyc) begin
          state_nx = ST_OWN1;
          grant_nx = GRANT_M1;
        end
      end

      ST_OWN0, ST_OWN1: begin
        s_cyc_c = sel_cyc;
        s_stb_c = sel_cyc ? sel_stb : 4'h0;
        wd_en   = sel_cyc;
        wd_clr  = s.ack;
        if (s.ack) begin
          // A slave ack on the terminal cycle beats the watchdog.
          rsp_ack = 1'b1;
          rsp_dat = s.rdat;
        end else if (wd_tc) begin
          s_cyc_c   = 1'b0;
          s_stb_c   = 4'h0;
          rsp_ack   = 1'b1;
          rsp_err   = 1'b1;
          rsp_dat   = TIMEOUT_DATA;
          timeout_c = 1'b1;
          state_nx  = ST_RELEASE;
        end
        if (!sel_cyc) begin
          state_nx = ST_IDLE;
          last_nx  = sel;
          grant_nx = GRANT_NONE;
        end
      end

      ST_RELEASE: begin
        if (!sel_cyc) begin
          state_nx = ST_IDLE;
          last_nx  = sel;
          grant_nx = GRANT_NONE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        grant_nx = GRANT_NONE;
      end
    endcase
  end

  assign s.cyc  = s_cyc_c;
  assign s.stb  = s_stb_c;
  assign s.we   = own & sel_we;
  assign s.addr = own ? sel_addr : 32'h0;
  assign s.wdat = own ? sel_wdat : 32'h0;

  assign m0.ack  = rsp_ack & ~sel;
  assign m0.err  = rsp_err & ~sel;
  assign m0.rdat = sel ? 32'h0 : rsp_dat;
  assign m1.ack  = rsp_ack & sel;
  assign m1.err  = rsp_err & sel;
  assign m1.rdat = sel ? rsp_dat : 32'h0;

  assign o_grant   = grant;
  assign o_timeout = timeout_c;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with TIMEOUT=4.
module tb_wb_arbiter2;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  wb_arbiter2_if m0_if ();
  wb_arbiter2_if m1_if ();
  wb_arbiter2_if s_if ();

  wb_arbiter2 #(
    .TIMEOUT      (4),
    .TO_W         (8),
    .TIMEOUT_DATA (32'hDEAD_BEEF)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .o_grant    (grant),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    m0_if.cyc  = 1'b0; m0_if.stb = 4'h0; m0_if.we = 1'b0; m0_if.addr = 32'h0; m0_if.wdat = 32'h0;
    m1_if.cyc  = 1'b0; m1_if.stb = 4'h0; m1_if.we = 1'b0; m1_if.addr = 32'h0; m1_if.wdat = 32'h0;
    s_if.ack   = 1'b0; s_if.rdat = 32'h0; s_if.err = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_cyc", 32'(s_if.cyc), 32'h0);
    chk("rst_m0_ack", 32'(m0_if.ack), 32'h0);
    chk("rst_m1_ack", 32'(m1_if.ack), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    #1 rst_n = 1'b1;

    // Single read, m0 only
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 4'hF; m0_if.addr = 32'h100;
    #1;
    chk("t1_grant_lat", 32'(grant), 32'h0);
    chk("t1_s_cyc_lat", 32'(s_if.cyc), 32'h0);
    step(); #1;
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_s_cyc", 32'(s_if.cyc), 32'h1);
    chk("t1_s_addr", s_if.addr, 32'h100);
    chk("t1_s_stb", 32'(s_if.stb), 32'hF);
    step();
    step();
    s_if.ack = 1'b1; s_if.rdat = 32'h1234_5678;
    #1;
    chk("t1_m0_ack", 32'(m0_if.ack), 32'h1);
    chk("t1_m0_dat", m0_if.rdat, 32'h1234_5678);
    chk("t1_m0_err", 32'(m0_if.err), 32'h0);
    chk("t1_m1_ack", 32'(m1_if.ack), 32'h0);
    chk("t1_m1_dat", m1_if.rdat, 32'h0);
    step();
    s_if.ack = 1'b0; m0_if.cyc = 1'b0;
    #1;
    chk("t1_s_cyc_drop", 32'(s_if.cyc), 32'h0);
    step(); #1;
    chk("t1_idle", 32'(grant), 32'h0);

    // Simultaneous requests from reset
    rst_n = 1'b0; #1 rst_n = 1'b1;
    step();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1; m1_if.addr = 32'h200; m1_if.stb = 4'h3;
    step(); #1;
    chk("t2_first", 32'(grant), 32'h1);
    chk("t2_s_addr0", s_if.addr, 32'h100);
    s_if.ack = 1'b1;
    #1;
    chk("t2_m0_ack", 32'(m0_if.ack), 32'h1);
    chk("t2_m1_noack", 32'(m1_if.ack), 32'h0);
    step();
    s_if.ack = 1'b0; m0_if.cyc = 1'b0;
    #1;
    chk("t2_hold", 32'(grant), 32'h1);
    step(); #1;
    chk("t2_idle_gap", 32'(grant), 32'h0);
    chk("t2_idle_cyc", 32'(s_if.cyc), 32'h0);
    step(); #1;
    chk("t2_second", 32'(grant), 32'h2);
    chk("t2_s_cyc1", 32'(s_if.cyc), 32'h1);
    chk("t2_s_addr1", s_if.addr, 32'h200);
    chk("t2_s_stb1", 32'(s_if.stb), 32'h3);
    m1_if.cyc = 1'b0;
    step(); #1;
    chk("t2_idle2", 32'(grant), 32'h0);
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    step(); #1;
    chk("t2_tie_again", 32'(grant), 32'h1);
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    step();
    step(); #1;
    chk("t2_idle3", 32'(grant), 32'h0);

    // Held grant: m1 bursts while m0 waits (m0 was last owner)
    m1_if.cyc = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h0; m1_if.wdat = 32'hA0;
    m0_if.cyc = 1'b1; m0_if.addr = 32'h300;
    step(); #1;
    chk("t3_grant_m1", 32'(grant), 32'h2);
    s_if.ack = 1'b1;
    #1;
    chk("t3_ack0", 32'(m1_if.ack), 32'h1);
    chk("t3_addr0", s_if.addr, 32'h0);
    chk("t3_we", 32'(s_if.we), 32'h1);
    chk("t3_wdat", s_if.wdat, 32'hA0);
    chk("t3_m0_noack", 32'(m0_if.ack), 32'h0);
    step();
    m1_if.addr = 32'h1; m1_if.wdat = 32'hA1;
    #1;
    chk("t3_grant1", 32'(grant), 32'h2);
    chk("t3_addr1", s_if.addr, 32'h1);
    chk("t3_ack1", 32'(m1_if.ack), 32'h1);
    step();
    m1_if.addr = 32'h2;
    #1;
    chk("t3_grant2", 32'(grant), 32'h2);
    chk("t3_addr2", s_if.addr, 32'h2);
    chk("t3_ack2", 32'(m1_if.ack), 32'h1);
    step();
    s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.we = 1'b0;
    #1;
    chk("t3_grant_drop", 32'(grant), 32'h2);
    step(); #1;
    chk("t3_idle", 32'(grant), 32'h0);
    step(); #1;
    chk("t3_m0_granted", 32'(grant), 32'h1);
    chk("t3_m0_addr", s_if.addr, 32'h300);
    m0_if.cyc = 1'b0;
    step();
    step();

    // Timeout: slave never acks
    m0_if.cyc = 1'b1; m0_if.addr = 32'h400;
    step(); #1;
    chk("t4_grant", 32'(grant), 32'h1);
    chk("t4_c1_to", 32'(timeout), 32'h0);
    step();
    step(); #1;
    chk("t4_c3_ack", 32'(m0_if.ack), 32'h0);
    chk("t4_c3_cyc", 32'(s_if.cyc), 32'h1);
    step(); #1;
    chk("t4_ack", 32'(m0_if.ack), 32'h1);
    chk("t4_err", 32'(m0_if.err), 32'h1);
    chk("t4_timeout", 32'(timeout), 32'h1);
    chk("t4_dat", m0_if.rdat, 32'hDEAD_BEEF);
    chk("t4_s_cyc", 32'(s_if.cyc), 32'h0);
    chk("t4_s_stb", 32'(s_if.stb), 32'h0);
    step();
    s_if.ack = 1'b1; s_if.rdat = 32'h55;
    #1;
    chk("t4_rel_cyc", 32'(s_if.cyc), 32'h0);
    chk("t4_rel_grant", 32'(grant), 32'h1);
    chk("t4_rel_ack_ign", 32'(m0_if.ack), 32'h0);
    chk("t4_rel_to", 32'(timeout), 32'h0);
    step();
    s_if.ack = 1'b0;
    #1;
    chk("t4_parked", 32'(grant), 32'h1);
    chk("t4_parked_cyc", 32'(s_if.cyc), 32'h0);
    m0_if.cyc = 1'b0;
    step(); #1;
    chk("t4_idle", 32'(grant), 32'h0);

    // Ack races the watchdog terminal cycle
    m0_if.cyc = 1'b1;
    step();
    step();
    step();
    step();
    s_if.ack = 1'b1; s_if.rdat = 32'hCAFE_F00D;
    #1;
    chk("t5_ack", 32'(m0_if.ack), 32'h1);
    chk("t5_err", 32'(m0_if.err), 32'h0);
    chk("t5_timeout", 32'(timeout), 32'h0);
    chk("t5_dat", m0_if.rdat, 32'hCAFE_F00D);
    chk("t5_s_cyc", 32'(s_if.cyc), 32'h1);
    step();
    s_if.ack = 1'b0;
    #1;
    chk("t5_after_to", 32'(timeout), 32'h0);
    chk("t5_after_cyc", 32'(s_if.cyc), 32'h1);
    m0_if.cyc = 1'b0;
    step();
    step();

    // Async reset mid-transfer in OWN1
    m1_if.cyc = 1'b1; m1_if.addr = 32'h600;
    step(); #1;
    chk("t6_grant", 32'(grant), 32'h2);
    s_if.ack = 1'b1;
    #1;
    chk("t6_ack_pre", 32'(m1_if.ack), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_s_cyc", 32'(s_if.cyc), 32'h0);
    chk("t6_grant_rst", 32'(grant), 32'h0);
    chk("t6_m1_ack", 32'(m1_if.ack), 32'h0);
    chk("t6_m0_ack", 32'(m0_if.ack), 32'h0);
    chk("t6_s_addr", s_if.addr, 32'h0);
    m0_if.cyc = 1'b1;
    step(); #1;
    chk("t6_held_rst", 32'(grant), 32'h0);
    rst_n = 1'b1; s_if.ack = 1'b0;
    step(); #1;
    chk("t6_tie_m0", 32'(grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
